// File: rtl/alu_nibble_serial.sv
// Nibble-serial add/subtract unit: one 4-bit ripple adder is reused per clock,
// LS nibble first, with the carry held in a register between slices.

module adder_ripple_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] c;

   always_comb begin
      sum  = '0;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[4];
   end
endmodule

module alu_nibble_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             overflow
);
   // state | meaning
   // IDLE  | waiting for start; outputs hold last completed op
   // RUN   | one nibble per clock through the adder, idx_q selects the slice
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] partial_q, partial_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             creg_q, creg_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic [3:0]       nib_a, nib_b, nib_sum;
   logic             nib_cout;
   logic [WIDTH-1:0] sum_full;

   adder_ripple_4bit u_adder (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (creg_q),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   // Slice select by constant-index compare keeps every part-select static.
   always_comb begin
      nib_a    = '0;
      nib_b    = '0;
      sum_full = partial_q;
      for (int n = 0; n < NIB; n++) begin
         if (idx_q == IW'(n)) begin
            nib_a              = opa_q[4*n +: 4];
            nib_b              = opb_q[4*n +: 4];
            sum_full[4*n +: 4] = nib_sum;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      partial_d = partial_q;
      idx_d     = idx_q;
      creg_d    = creg_q;
      done_d    = 1'b0;
      result_d  = result_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = op_sub ? ~b : b;
               creg_d  = op_sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            partial_d = sum_full;
            creg_d    = nib_cout;
            idx_d     = idx_q + IW'(1);
            if (idx_q == IW'(NIB - 1)) begin
               result_d = sum_full;
               carry_d  = nib_cout;
               zero_d   = (sum_full == '0);
               ovf_d    = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                          (sum_full[WIDTH-1] != opa_q[WIDTH-1]);
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         opa_q     <= '0;
         opb_q     <= '0;
         partial_q <= '0;
         idx_q     <= '0;
         creg_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         partial_q <= partial_d;
         idx_q     <= idx_d;
         creg_q    <= creg_d;
         done_q    <= done_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign result   = result_q;
   assign carry    = carry_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_alu_nibble_serial.sv
// Directed bench for alu_nibble_serial: WIDTH=8 instance for the main ops,
// WIDTH=16 instance for the wide carry-chain case.

module tb_alu_nibble_serial;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, op_sub = 1'b0;
   logic [7:0]  a = '0, b = '0;
   logic        busy, done, carry, zero, overflow;
   logic [7:0]  result;

   logic        start16 = 1'b0, op_sub16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, carry16, zero16, overflow16;
   logic [15:0] result16;

   int checks = 0;
   int errors = 0;
   logic [7:0] last_res = '0;

   always #5 clk = ~clk;

   alu_nibble_serial #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
      .overflow(overflow)
   );

   alu_nibble_serial #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .op_sub(op_sub16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .result(result16), .carry(carry16), .zero(zero16),
      .overflow(overflow16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [7:0] r, input logic c,
                           input logic z, input logic v);
      chk({tag, " result"}, {24'd0, result}, {24'd0, r});
      chk({tag, " carry"}, {31'd0, carry}, {31'd0, c});
      chk({tag, " zero"}, {31'd0, zero}, {31'd0, z});
      chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, v});
   endtask

   // Full op on the 8-bit instance; operands are scrambled while busy.
   task automatic run8(input string tag, input logic sub, input logic [7:0] va,
                       input logic [7:0] vb, input logic [7:0] r, input logic c,
                       input logic z, input logic v);
      @(negedge clk);
      start = 1'b1; op_sub = sub; a = va; b = vb;
      @(posedge clk); #1;
      start = 1'b0; a = ~va; b = ~vb; op_sub = ~sub;
      chk({tag, " busy c0"}, {31'd0, busy}, 32'd1);
      chk({tag, " done c0"}, {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      chk({tag, " done c1"}, {31'd0, done}, 32'd0);
      chk({tag, " hold c1"}, {24'd0, result}, {24'd0, last_res});
      @(posedge clk); #1;
      chk({tag, " done c2"}, {31'd0, done}, 32'd1);
      chk({tag, " busy c2"}, {31'd0, busy}, 32'd0);
      chk_outs(tag, r, c, z, v);
      last_res = r;
      @(posedge clk); #1;
      chk({tag, " done c3"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      #1;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk_outs("rst", 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk); rst_n = 1'b1;

      run8("add0F01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0);
      run8("addFF01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
      run8("add7F01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
      run8("sub0505", 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
      run8("sub0305", 1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0);
      run8("sub8001", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1);

      // start held high with operands changing, then restart on the done cycle
      @(negedge clk);
      start = 1'b1; op_sub = 1'b0; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      a = 8'h99; b = 8'h99; op_sub = 1'b1;
      chk("hold busy c0", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      a = 8'h55; b = 8'h66;
      chk("hold done c1", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      chk("hold done c2", {31'd0, done}, 32'd1);
      chk_outs("hold", 8'h33, 1'b0, 1'b0, 1'b0);
      a = 8'h40; b = 8'h02; op_sub = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b busy c0", {31'd0, busy}, 32'd1);
      chk("b2b done c0", {31'd0, done}, 32'd0);
      chk("b2b hold c0", {24'd0, result}, 32'h33);
      @(posedge clk); #1;
      chk("b2b busy c1", {31'd0, busy}, 32'd1);
      chk("b2b done c1", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      chk("b2b done c2", {31'd0, done}, 32'd1);
      chk_outs("b2b", 8'h3E, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("b2b done c3", {31'd0, done}, 32'd0);

      // async reset in the middle of RUN
      @(negedge clk);
      start = 1'b1; op_sub = 1'b0; a = 8'h12; b = 8'h34;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("abort busy pre", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk_outs("abort", 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("abort done rst", {31'd0, done}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort no done", {31'd0, done}, 32'd0);
      chk("abort idle", {31'd0, busy}, 32'd0);
      last_res = 8'h00;
      run8("post1234", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);

      // 16-bit instance: four nibble cycles
      @(negedge clk);
      start16 = 1'b1; op_sub16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h0001;
      @(posedge clk); #1;
      start16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
      chk("w16 busy c0", {31'd0, busy16}, 32'd1);
      for (int k = 1; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("w16 done c%0d", k), {31'd0, done16}, 32'd0);
         chk($sformatf("w16 hold c%0d", k), {16'd0, result16}, 32'h0);
      end
      @(posedge clk); #1;
      chk("w16 done c4", {31'd0, done16}, 32'd1);
      chk("w16 result", {16'd0, result16}, 32'h0000);
      chk("w16 carry", {31'd0, carry16}, 32'd1);
      chk("w16 zero", {31'd0, zero16}, 32'd1);
      chk("w16 overflow", {31'd0, overflow16}, 32'd0);
      @(posedge clk); #1;
      chk("w16 done c5", {31'd0, done16}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
